// File: rtl/aes_key_expander.sv
// AES-128 key schedule: captures a cipher key and expands 44 words, one word per clock.
// Latency: 40 cycles from the key_start edge to the key_expand_done pulse; rk_out is combinational.
// Backpressure: none; key_start is ignored while expanding. Optional debug ports: define KEYEXP_DBG_EN.

module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);
  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry for byte b sits at bit offset (255-b)*8, and 255-b is simply ~b.
  assign result = SBOX_TABLE[{~data, 3'b000} +: 8];
endmodule

module aes_key_expander (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         key_start,
  input  logic [127:0] key_in,
  input  logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         key_busy,
  output logic         key_ready,
  output logic         key_expand_done
`ifdef KEYEXP_DBG_EN
  ,
  output logic [1:0]   dbg_kx_state,
  output logic [5:0]   dbg_kx_word
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] w [0:43];
  logic [5:0]  cnt;
  logic [31:0] prev;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] temp;
  logic [31:0] rcon;
  logic        load;

  // A start is only honoured when not already expanding.
  assign load = key_start && ((state == IDLE) || (state == DONE));

  assign prev = w[cnt - 6'd1];
  assign rot  = {prev[23:0], prev[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .data   (rot[8*b +: 8]),
      .result (sub[8*b +: 8])
    );
  end

  // Round constant for word i, indexed by i/4 and placed in the top byte.
  always_comb begin
    rcon = 32'h0;
    case (cnt[5:2])
      4'd1:    rcon = 32'h01000000;
      4'd2:    rcon = 32'h02000000;
      4'd3:    rcon = 32'h04000000;
      4'd4:    rcon = 32'h08000000;
      4'd5:    rcon = 32'h10000000;
      4'd6:    rcon = 32'h20000000;
      4'd7:    rcon = 32'h40000000;
      4'd8:    rcon = 32'h80000000;
      4'd9:    rcon = 32'h1b000000;
      4'd10:   rcon = 32'h36000000;
      default: rcon = 32'h0;
    endcase
  end

  // Every fourth word goes through RotWord/SubWord/Rcon; the rest reuse w[i-1].
  always_comb begin
    temp = prev;
    if (cnt[1:0] == 2'b00) begin
      temp = sub ^ rcon;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start from IDLE/DONE, finish after word 43 is written.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (key_start) begin
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (cnt == 6'd43) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word file, word counter and completion pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < 44; j++) begin
        w[j] <= 32'h0;
      end
      cnt             <= 6'd0;
      key_expand_done <= 1'b0;
    end else begin
      key_expand_done <= (state == EXPAND) && (cnt == 6'd43);
      if (load) begin
        w[0] <= key_in[127:96];
        w[1] <= key_in[95:64];
        w[2] <= key_in[63:32];
        w[3] <= key_in[31:0];
        cnt  <= 6'd4;
      end else if (state == EXPAND) begin
        w[cnt] <= w[cnt - 6'd4] ^ temp;
        cnt    <= cnt + 6'd1;
      end
    end
  end

  assign key_busy  = (state == EXPAND);
  assign key_ready = (state == DONE);

  // Round-key read port; out-of-range rounds read as zero.
  always_comb begin
    rk_out = 128'h0;
    if (rk_round <= 4'd10) begin
      rk_out = {w[{rk_round, 2'b00}], w[{rk_round, 2'b01}],
                w[{rk_round, 2'b10}], w[{rk_round, 2'b11}]};
    end
  end

`ifdef KEYEXP_DBG_EN
  assign dbg_kx_state = state;
  assign dbg_kx_word  = cnt;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_start = 1'b0;
  logic [127:0] key_in = 128'h0;
  logic [3:0]   rk_round = 4'd0;
  logic [127:0] rk_out;
  logic         key_busy;
  logic         key_ready;
  logic         key_expand_done;
`ifdef KEYEXP_DBG_EN
  logic [1:0]   dbg_kx_state;
  logic [5:0]   dbg_kx_word;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] mw [44];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expander dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .key_start       (key_start),
    .key_in          (key_in),
    .rk_round        (rk_round),
    .rk_out          (rk_out),
    .key_busy        (key_busy),
    .key_ready       (key_ready),
    .key_expand_done (key_expand_done)
`ifdef KEYEXP_DBG_EN
    ,
    .dbg_kx_state    (dbg_kx_state),
    .dbg_kx_word     (dbg_kx_word)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (GF(2^8) arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) mw[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = mw[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      mw[i] = mw[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Start an expansion and watch 45 cycles: first done-pulse cycle, pulse count, level errors.
  task automatic run_start(input logic [127:0] k, input int x1, input int x2,
                           output int first, output int npulse, output int badlvl);
    @(negedge clock);
    key_in = k;
    key_start = 1'b1;
    @(negedge clock);
    key_start = 1'b0;
    key_in = rand_key();
    first = -1;
    npulse = 0;
    badlvl = 0;
    if (key_busy !== 1'b1 || key_ready !== 1'b0 || key_expand_done !== 1'b0) badlvl++;
    for (int c = 1; c <= 45; c++) begin
      if (c == x1 || c == x2) begin
        key_start = 1'b1;
        key_in = rand_key();
      end
      @(negedge clock);
      key_start = 1'b0;
      if (key_expand_done === 1'b1) begin
        npulse++;
        if (first < 0) first = c;
      end
      if (key_busy !== (c < 40)) badlvl++;
      if (key_ready !== (c >= 40)) badlvl++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    key_start = 1'b1;
    key_in = rand_key();
    @(negedge clock);
    checks++;
    if ({key_busy, key_ready, key_expand_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {key_busy, key_ready, key_expand_done});
    end
    for (int r = 0; r < 16; r++) begin
      rk_round = r[3:0];
      #1;
      checks++;
      if (rk_out !== 128'h0) begin
        errors++;
        $display("FAIL reset_rk r=%0d got %h want 0", r, rk_out);
      end
    end
    key_start = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if ({key_busy, key_ready, key_expand_done} !== 3'b000) begin
        errors++;
        $display("FAIL idle_hold cycle %0d got %b want 000", c, {key_busy, key_ready, key_expand_done});
      end
    end
  endtask

  task automatic test_fips();
    int first, npulse, badlvl;
    run_start(FIPS_KEY, 0, 0, first, npulse, badlvl);
    checks++;
    if (first !== 40 || npulse !== 1 || badlvl !== 0) begin
      errors++;
      $display("FAIL fips_timing got first=%0d pulses=%0d badlvl=%0d want 40/1/0", first, npulse, badlvl);
    end
    rk_round = 4'd0; #1; checks++;
    if (rk_out !== FIPS_KEY) begin
      errors++; $display("FAIL fips_rk0 got %h want %h", rk_out, FIPS_KEY);
    end
    rk_round = 4'd1; #1; checks++;
    if (rk_out !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      errors++; $display("FAIL fips_rk1 got %h want a0fafe1788542cb123a339392a6c7605", rk_out);
    end
    rk_round = 4'd10; #1; checks++;
    if (rk_out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL fips_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk_out);
    end
    model_expand(FIPS_KEY);
    for (int r = 0; r < 11; r++) begin
      rk_round = r[3:0]; #1; checks++;
      if (rk_out !== model_rk(r)) begin
        errors++; $display("FAIL fips_model r=%0d got %h want %h", r, rk_out, model_rk(r));
      end
    end
  endtask

  task automatic test_zero_key();
    int first, npulse, badlvl;
    run_start(128'h0, 0, 0, first, npulse, badlvl);
    checks++;
    if (first !== 40 || npulse !== 1 || badlvl !== 0) begin
      errors++;
      $display("FAIL zero_timing got first=%0d pulses=%0d badlvl=%0d want 40/1/0", first, npulse, badlvl);
    end
    rk_round = 4'd1; #1; checks++;
    if (rk_out !== 128'h62636363626363636263636362636363) begin
      errors++; $display("FAIL zero_rk1 got %h want 62636363626363636263636362636363", rk_out);
    end
    rk_round = 4'd10; #1; checks++;
    if (rk_out !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      errors++; $display("FAIL zero_rk10 got %h want b4ef5bcb3e92e21123e951cf6f8f188e", rk_out);
    end
    for (int r = 11; r < 16; r++) begin
      rk_round = r[3:0]; #1; checks++;
      if (rk_out !== 128'h0) begin
        errors++; $display("FAIL rk_out_of_range r=%0d got %h want 0", r, rk_out);
      end
    end
  endtask

  task automatic test_ignore_start();
    int first, npulse, badlvl;
    run_start(FIPS_KEY, 5, 20, first, npulse, badlvl);
    checks++;
    if (first !== 40 || npulse !== 1 || badlvl !== 0) begin
      errors++;
      $display("FAIL ignore_timing got first=%0d pulses=%0d badlvl=%0d want 40/1/0", first, npulse, badlvl);
    end
    model_expand(FIPS_KEY);
    for (int r = 0; r < 11; r++) begin
      rk_round = r[3:0]; #1; checks++;
      if (rk_out !== model_rk(r)) begin
        errors++; $display("FAIL ignore_model r=%0d got %h want %h", r, rk_out, model_rk(r));
      end
    end
  endtask

  task automatic test_reset_mid();
    int first, npulse, badlvl, pulses;
    @(negedge clock);
    key_in = FIPS_KEY;
    key_start = 1'b1;
    @(negedge clock);
    key_start = 1'b0;
    repeat (17) @(negedge clock);
    reset_n = 1'b0;
    #1;
    rk_round = 4'd0;
    #1;
    checks++;
    if ({key_busy, key_ready, key_expand_done} !== 3'b000 || rk_out !== 128'h0) begin
      errors++;
      $display("FAIL midreset_state got flags=%b rk0=%h want 000/0", {key_busy, key_ready, key_expand_done}, rk_out);
    end
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clock);
      if (key_expand_done === 1'b1 || key_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL midreset_quiet got %0d done/ready cycles want 0", pulses);
    end
    run_start(128'h0, 0, 0, first, npulse, badlvl);
    checks++;
    if (first !== 40 || npulse !== 1 || badlvl !== 0) begin
      errors++;
      $display("FAIL midreset_restart got first=%0d pulses=%0d badlvl=%0d want 40/1/0", first, npulse, badlvl);
    end
    model_expand(128'h0);
    for (int r = 0; r < 11; r++) begin
      rk_round = r[3:0]; #1; checks++;
      if (rk_out !== model_rk(r)) begin
        errors++; $display("FAIL midreset_model r=%0d got %h want %h", r, rk_out, model_rk(r));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ka, kb;
    int c;
    ka = rand_key();
    kb = rand_key();
    @(negedge clock);
    key_in = ka;
    key_start = 1'b1;
    @(negedge clock);
    key_start = 1'b0;
    c = 0;
    while (key_expand_done !== 1'b1 && c < 60) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (c !== 40) begin
      errors++; $display("FAIL b2b_first_latency got %0d want 40", c);
    end
    key_in = kb;
    key_start = 1'b1;
    @(negedge clock);
    key_start = 1'b0;
    checks++;
    if ({key_busy, key_ready, key_expand_done} !== 3'b100) begin
      errors++; $display("FAIL b2b_restart_flags got %b want 100", {key_busy, key_ready, key_expand_done});
    end
    c = 0;
    while (key_expand_done !== 1'b1 && c < 60) begin
      @(negedge clock);
      c++;
    end
    checks++;
    if (c !== 40) begin
      errors++; $display("FAIL b2b_second_latency got %0d want 40", c);
    end
`ifdef KEYEXP_DBG_EN
    checks++;
    if (dbg_kx_word !== 6'd44 || dbg_kx_state !== 2'd2) begin
      errors++; $display("FAIL dbg_done got word=%0d state=%0d want 44/2", dbg_kx_word, dbg_kx_state);
    end
`endif
    model_expand(kb);
    for (int r = 0; r < 11; r++) begin
      rk_round = r[3:0]; #1; checks++;
      if (rk_out !== model_rk(r)) begin
        errors++; $display("FAIL b2b_model r=%0d got %h want %h", r, rk_out, model_rk(r));
      end
    end
  endtask

  task automatic test_random();
    int first, npulse, badlvl;
    logic [127:0] k;
    for (int n = 0; n < 4; n++) begin
      k = rand_key();
      run_start(k, 0, 0, first, npulse, badlvl);
      checks++;
      if (first !== 40 || npulse !== 1 || badlvl !== 0) begin
        errors++;
        $display("FAIL rand_timing key=%h got first=%0d pulses=%0d badlvl=%0d want 40/1/0", k, first, npulse, badlvl);
      end
      model_expand(k);
      for (int r = 0; r < 11; r++) begin
        rk_round = r[3:0]; #1; checks++;
        if (rk_out !== model_rk(r)) begin
          errors++; $display("FAIL rand_model key=%h r=%0d got %h want %h", k, r, rk_out, model_rk(r));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_zero_key();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
